large_divider: RTL

- Sequential restoring divider that undoes the large-number multiplier.
- Takes a 2W-bit dividend, such as the 2048-bit multiplier product, and a W-bit divisor, and returns a 2W-bit quotient and a W-bit remainder.
- Used to check multiplier results in a round trip (product / In2 == In1, remainder 0), and as the modular-reduction primitive in the large-number datapath.
- Produces one quotient bit per cycle; start/busy/done handshake.

---
 rtl/large_divider_if.sv | 26 ++
 rtl/large_divider.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/large_divider_if.sv
// large_divider_if -- operand/result bundle for large_divider.
//   master : requester side (drives start, Dividend, Divisor)
//   slave  : divider side   (drives busy, done, Quo, Rem, dbz)
// W is the divisor/remainder width; dividend and quotient are 2*W bits.
interface large_divider_if #(
    parameter int W = 1024
);
    logic             start;
    logic [2*W-1:0]   Dividend;
    logic [W-1:0]     Divisor;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   Quo;
    logic [W-1:0]     Rem;
    logic             dbz;

    modport master (
        output start, Dividend, Divisor,
        input  busy, done, Quo, Rem, dbz
    );

    modport slave (
        input  start, Dividend, Divisor,
        output busy, done, Quo, Rem, dbz
    );
endinterface

// File: rtl/large_divider.sv
// large_divider -- sequential restoring divider, one quotient bit per cycle.
// Divides a 2W-bit dividend by a W-bit divisor giving a 2W-bit quotient and
// a W-bit remainder. Used to undo the large-number multiplier and as the
// modular-reduction primitive.
//
// Ports:
//   clk  : system clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : large_divider_if.slave
//            start (in)    request, sampled only while idle
//            Dividend/Divisor (in) captured on the accepting edge
//            busy (out)    high while a division is in progress
//            done (out)    one-cycle pulse, results valid from this cycle
//            Quo/Rem/dbz (out) held until the next accepted start completes
//
// Optional build macro: LDIV_SKIP_ZEROS_EN
//   When defined, leading zeros of the dividend are skipped at start, so
//   the run takes 2W-lz steps instead of 2W. Results are unchanged.
module large_divider #(
    parameter int W  = 1024,
    parameter int CW = 12
) (
    input  logic           clk,
    input  logic           rstn,
    large_divider_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    localparam logic [CW-1:0] LAST = CW'(2*W-1);

    logic [1:0]     state_q, state_d;
    logic [2*W-1:0] D_q, D_d;
    logic [W-1:0]   V_q, V_d;
    logic [W:0]     P_q, P_d;
    logic [2*W-1:0] Q_q, Q_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           zero_q, zero_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [2*W-1:0] quo_q, quo_d;
    logic [W-1:0]   rem_q, rem_d;
    logic           dbz_q, dbz_d;

    // Restoring step: shift next dividend bit into the partial remainder and
    // subtract the divisor when it fits.
    logic [W:0] t_w, diff_w;
    logic       ge_w;

    assign t_w    = {P_q[W-1:0], D_q[2*W-1]};
    assign ge_w   = (t_w >= {1'b0, V_q});
    assign diff_w = t_w - {1'b0, V_q};

`ifdef LDIV_SKIP_ZEROS_EN
    // Leading-zero count of the incoming dividend; 2W when it is zero.
    logic [CW-1:0] lz_w;
    logic          found_w;

    always_comb begin
        lz_w    = CW'(2*W);
        found_w = 1'b0;
        for (int i = 2*W-1; i >= 0; i--) begin
            if (!found_w && bus.Dividend[i]) begin
                lz_w    = CW'(2*W-1-i);
                found_w = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        D_d     = D_q;
        V_d     = V_q;
        P_d     = P_q;
        Q_d     = Q_q;
        cnt_d   = cnt_q;
        zero_d  = zero_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    D_d    = bus.Dividend;
                    V_d    = bus.Divisor;
                    P_d    = '0;
                    Q_d    = '0;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                    if (bus.Divisor == '0) begin
                        zero_d  = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        zero_d  = 1'b0;
                        state_d = S_RUN;
`ifdef LDIV_SKIP_ZEROS_EN
                        // Starting the count at lz keeps the common RUN
                        // exit test; a zero dividend has nothing to divide.
                        D_d   = bus.Dividend << lz_w;
                        cnt_d = lz_w;
                        if (lz_w == CW'(2*W))
                            state_d = S_FIN;
`endif
                    end
                end
            end
            S_RUN: begin
                P_d   = ge_w ? diff_w : t_w;
                Q_d   = {Q_q[2*W-2:0], ge_w};
                D_d   = D_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST)
                    state_d = S_FIN;
            end
            S_FIN: begin
                if (zero_q) begin
                    // D was never shifted, so its low half is the dividend's.
                    quo_d = '1;
                    rem_d = D_q[W-1:0];
                    dbz_d = 1'b1;
                end else begin
                    quo_d = Q_q;
                    rem_d = P_q[W-1:0];
                    dbz_d = 1'b0;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            D_q     <= '0;
            V_q     <= '0;
            P_q     <= '0;
            Q_q     <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            D_q     <= D_d;
            V_q     <= V_d;
            P_q     <= P_d;
            Q_q     <= Q_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.Quo  = quo_q;
    assign bus.Rem  = rem_q;
    assign bus.dbz  = dbz_q;
endmodule
